// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer: PC -> AR, memory read with wait-state timeout, IR load, PC increment.
module fetch_unit #(
  parameter int reg_width  = 12,
  parameter int data_width = 16,
  parameter int max_wait   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [reg_width-1:0]  pc_in,
  input  logic                  mem_ready,
  input  logic [data_width-1:0] mem_data_in,
  output logic [reg_width-1:0]  ar_out,
  output logic                  mem_rd,
  output logic [data_width-1:0] ir_out,
  output logic                  pc_increment,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);

  typedef enum logic [1:0] {IDLE, WAIT, INC} state_t;

  // Counter value at which an unanswered read is abandoned.
  localparam logic [7:0] last_cnt = 8'(max_wait - 1);

  state_t                state_q, state_d;
  logic [reg_width-1:0]  ar_q, ar_d;
  logic [data_width-1:0] ir_q, ir_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  pc_inc_q, pc_inc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;

  always_comb begin
    state_d  = state_q;
    ar_d     = ar_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    mem_rd_d = 1'b0;
    pc_inc_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ar_d     = pc_in;
          mem_rd_d = 1'b1;
          cnt_d    = 8'd0;
          fault_d  = 1'b0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          ir_d     = mem_data_in;
          pc_inc_d = 1'b1;
          state_d  = INC;
        end else if (cnt_q == last_cnt) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          mem_rd_d = 1'b1;
        end
      end
      INC: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy is registered, so it tracks the state being entered.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ar_q     <= '0;
      ir_q     <= '0;
      cnt_q    <= 8'd0;
      mem_rd_q <= 1'b0;
      pc_inc_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ar_q     <= ar_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      mem_rd_q <= mem_rd_d;
      pc_inc_q <= pc_inc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign ar_out       = ar_q;
  assign ir_out       = ir_q;
  assign mem_rd       = mem_rd_q;
  assign pc_increment = pc_inc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, start, mem_ready;
  logic [11:0] pc_in;
  logic [15:0] mem_data_in;
  logic [11:0] ar_out;
  logic [15:0] ir_out;
  logic        mem_rd, pc_increment, busy, done, fault;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.reg_width(12), .data_width(16), .max_wait(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in),
    .mem_ready(mem_ready), .mem_data_in(mem_data_in),
    .ar_out(ar_out), .mem_rd(mem_rd), .ir_out(ir_out),
    .pc_increment(pc_increment), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic rd, input logic inc,
                           input logic dn, input logic bs, input logic flt);
    chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(rd));
    chk({tag, ".pc_increment"}, 32'(pc_increment), 32'(inc));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".busy"}, 32'(busy), 32'(bs));
    chk({tag, ".fault"}, 32'(fault), 32'(flt));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0;
    pc_in = 12'h000; mem_data_in = 16'h0000;

    // Reset state
    tick();
    reset = 1'b0;
    chk("rst.ar", 32'(ar_out), 32'h0);
    chk("rst.ir", 32'(ir_out), 32'h0);
    chk_flags("rst", 0, 0, 0, 0, 0);

    // Zero-wait fetch
    pc_in = 12'h0E8; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zw.e0.ar", 32'(ar_out), 32'h0E8);
    chk_flags("zw.e0", 1, 0, 0, 1, 0);
    mem_ready = 1'b1; mem_data_in = 16'hA5C3;
    tick();
    mem_ready = 1'b0;
    chk("zw.e1.ir", 32'(ir_out), 32'hA5C3);
    chk_flags("zw.e1", 0, 1, 0, 1, 0);
    tick();
    chk_flags("zw.e2", 0, 0, 1, 0, 0);
    tick();
    chk_flags("zw.e3", 0, 0, 0, 0, 0);
    chk("zw.e3.ar", 32'(ar_out), 32'h0E8);

    // Three wait states
    pc_in = 12'h100; start = 1'b1;
    tick();
    start = 1'b0;
    pc_in = 12'h555;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_flags($sformatf("w3.wait%0d", i), 1, 0, 0, 1, 0);
      chk($sformatf("w3.wait%0d.ar", i), 32'(ar_out), 32'h100);
    end
    mem_ready = 1'b1; mem_data_in = 16'h1234;
    tick();
    mem_ready = 1'b0;
    chk_flags("w3.load", 0, 1, 0, 1, 0);
    chk("w3.ir", 32'(ir_out), 32'h1234);
    tick();
    chk_flags("w3.done", 0, 0, 1, 0, 0);
    tick();

    // Timeout
    pc_in = 12'h200; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_flags($sformatf("to.wait%0d", i), 1, 0, 0, 1, 0);
    end
    tick();
    chk_flags("to.expire", 0, 0, 0, 0, 1);
    chk("to.ir", 32'(ir_out), 32'h1234);
    chk("to.ar", 32'(ar_out), 32'h200);
    tick();
    tick();
    chk_flags("to.sticky", 0, 0, 0, 0, 1);
    pc_in = 12'h300; start = 1'b1;
    tick();
    start = 1'b0;
    chk_flags("to.restart", 1, 0, 0, 1, 0);
    chk("to.restart.ar", 32'(ar_out), 32'h300);
    mem_ready = 1'b1; mem_data_in = 16'h5555;
    tick();
    mem_ready = 1'b0;
    tick();
    chk_flags("to.rdone", 0, 0, 1, 0, 0);
    chk("to.rdone.ir", 32'(ir_out), 32'h5555);
    tick();

    // start during WAIT/INC ignored, start in done cycle accepted
    pc_in = 12'h0E8; start = 1'b1;
    tick();
    pc_in = 12'h0FF;
    tick();
    chk("ig.wait.ar", 32'(ar_out), 32'h0E8);
    chk_flags("ig.wait", 1, 0, 0, 1, 0);
    mem_ready = 1'b1; mem_data_in = 16'h0BEE;
    tick();
    chk("ig.inc.ar", 32'(ar_out), 32'h0E8);
    chk_flags("ig.inc", 0, 1, 0, 1, 0);
    mem_data_in = 16'hDEAD;
    tick();
    mem_ready = 1'b0;
    chk("ig.done.ar", 32'(ar_out), 32'h0E8);
    chk("ig.done.ir", 32'(ir_out), 32'h0BEE);
    chk_flags("ig.done", 0, 0, 1, 0, 0);
    pc_in = 12'h0E9;
    tick();
    start = 1'b0;
    chk("ig.accept.ar", 32'(ar_out), 32'h0E9);
    chk_flags("ig.accept", 1, 0, 0, 1, 0);
    mem_ready = 1'b1; mem_data_in = 16'h7777;
    tick();
    mem_ready = 1'b0;
    tick();
    chk_flags("ig.fin", 0, 0, 1, 0, 0);
    tick();

    // Reset mid-fetch with mem_ready on the same edge
    pc_in = 12'h123; start = 1'b1;
    tick();
    start = 1'b0;
    mem_ready = 1'b1; mem_data_in = 16'h9999; reset = 1'b1;
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    chk("mr.ar", 32'(ar_out), 32'h0);
    chk("mr.ir", 32'(ir_out), 32'h0);
    chk_flags("mr", 0, 0, 0, 0, 0);
    tick();
    chk_flags("mr.after", 0, 0, 0, 0, 0);

    // mem_ready while IDLE ignored
    pc_in = 12'h010; start = 1'b1;
    tick();
    start = 1'b0;
    mem_ready = 1'b1; mem_data_in = 16'h4321;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    chk("id.pre.ir", 32'(ir_out), 32'h4321);
    mem_ready = 1'b1; mem_data_in = 16'hFFFF;
    tick();
    tick();
    mem_ready = 1'b0;
    chk("id.ir", 32'(ir_out), 32'h4321);
    chk("id.ar", 32'(ar_out), 32'h010);
    chk_flags("id", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter reg_width, default 12, address width (matches PC output).
REQ-002 SHALL have parameter data_width, default 16, instruction width.
REQ-003 SHALL have parameter max_wait, default 8, memory wait-state limit in cycles (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request one instruction fetch.
REQ-007 SHALL have port pc_in  input  reg_width  current PC value (PC AR_data_out).
REQ-008 SHALL have port mem_ready  input  1  memory read data valid this cycle.
REQ-009 SHALL have port mem_data_in  input  data_width  memory read data.
REQ-010 SHALL have port ar_out  output  reg_width  address register, drives memory address.
REQ-011 SHALL have port mem_rd  output  1  memory read strobe.
REQ-012 SHALL have port ir_out  output  data_width  instruction register.
REQ-013 SHALL have port pc_increment  output  1  one-cycle pulse to PC increment input.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse, fetch completed.
REQ-016 SHALL have port fault  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, INC; all outputs registered.
REQ-018 IDLE, start=1: ar_out<=pc_in, mem_rd<=1, wait counter<=0, fault<=0, next WAIT.
REQ-019 IDLE, start=0: hold all registers; mem_rd=0, pc_increment=0.
REQ-020 WAIT, mem_ready=1: ir_out<=mem_data_in, mem_rd<=0, pc_increment<=1, next INC.
REQ-021 WAIT, mem_ready=0, counter<max_wait-1: counter increments, mem_rd stays 1, ar_out stable.
REQ-022 WAIT, mem_ready=0, counter=max_wait-1: mem_rd<=0, fault<=1, next IDLE; ir_out and ar_out unchanged, no pc_increment, no done.
REQ-023 INC: pc_increment<=0, done<=1, next IDLE; done and pc_increment each high exactly one cycle.
REQ-024 Zero-wait latency: start sampled at edge E0 -> mem_rd high E0..E1, ir_out valid after E1, pc_increment high E1..E2, done high E2..E3.
REQ-025 start while busy=1 SHALL be ignored (no queuing).
REQ-026 start in the IDLE cycle where done=1 SHALL be accepted; pc_in then holds the incremented PC.
REQ-027 mem_ready in IDLE or INC SHALL be ignored.
REQ-028 ar_out SHALL change only on accepted start; never wraps or modifies pc_in value.
REQ-029 fault SHALL remain 1 until next accepted start or reset.

Reset
REQ-030 reset=1 at rising edge SHALL force IDLE, ar_out=0, ir_out=0, mem_rd=0, pc_increment=0, done=0, fault=0, busy=0, counter=0.
REQ-031 reset SHALL take priority over all inputs, including mid-fetch in WAIT or INC; aborted fetch emits no pc_increment or done.

Verification
REQ-032 reset 1 cycle, pc_in=12'h0E8, start 1 cycle, mem_ready=1 next cycle with 16'hA5C3 -> ar_out=0x0E8, ir_out=0xA5C3, one pc_increment then one done, 3 cycles start-to-done.
REQ-033 start, mem_ready after 3 wait cycles -> mem_rd high 4 cycles, ar_out stable, single pc_increment.
REQ-034 start, mem_ready never (max_wait=8) -> mem_rd drops after 8 cycles, fault=1, no done, ir_out unchanged; next start clears fault.
REQ-035 start pulsed during WAIT and INC -> ignored; start in done cycle with pc_in=0x0E9 -> ar_out=0x0E9.
REQ-036 reset asserted in WAIT with mem_ready=1 same edge -> all outputs zero, no pc_increment, ir_out=0.
REQ-037 mem_ready=1 with data 16'hFFFF while IDLE -> ir_out unchanged, no pulses.
